// File: rtl/debounce_multi_us_pkg.sv
// Shared helpers for the multi-channel debouncer: debounce length in clocks
// and the counter width needed to hold it.
package debounce_multi_us_pkg;

  // Stable time in clocks, clamped so a zero-length setting still registers once.
  function automatic int debounce_cycles(input int clk_hz, input int us);
    int cyc;
    cyc = (clk_hz / 1_000_000) * us;
    return (cyc < 1) ? 1 : cyc;
  endfunction

  function automatic int cnt_width(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/debounce_multi_us_channel.sv
// Single-channel debouncer: 2-flop synchroniser, stability counter, output bit.
// Latency: 2 + DEBOUNCE_CYCLES clocks for a clean step; no backpressure (free-running).
// DEBOUNCE_GLITCH_CNT_EN adds a saturating 8-bit count of aborted transitions.
module debounce_channel
  import debounce_multi_us_pkg::*;
#(
  parameter int   CLK_FREQ_HZ      = 50_000_000,
  parameter int   DEBOUNCE_TIME_US = 50,
  parameter logic RESET_BIT        = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic signal_in,
  output logic signal_out,
  output logic update
`ifdef DEBOUNCE_GLITCH_CNT_EN
  ,
  output logic [7:0] glitch_count
`endif
);

  localparam int DC = debounce_cycles(CLK_FREQ_HZ, DEBOUNCE_TIME_US);
  localparam int CW = cnt_width(DC);
  localparam logic [CW-1:0] TERM = CW'(DC - 1);

  logic          sync_q1;
  logic          sync_q2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q1 <= RESET_BIT;
      sync_q2 <= RESET_BIT;
    end else begin
      sync_q1 <= signal_in;
      sync_q2 <= sync_q1;
    end
  end

  // Terminal count always clears the counter, so it can never wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      signal_out <= RESET_BIT;
      update     <= 1'b0;
    end else begin
      update <= 1'b0;
      if (sync_q2 == signal_out) begin
        cnt <= '0;
      end else if (cnt == TERM) begin
        cnt        <= '0;
        signal_out <= sync_q2;
        update     <= 1'b1;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

`ifdef DEBOUNCE_GLITCH_CNT_EN
  // A nonzero count with sync back at the output level is an aborted transition.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      glitch_count <= '0;
    end else if ((sync_q2 == signal_out) && (cnt != '0) && (glitch_count != 8'hFF)) begin
      glitch_count <= glitch_count + 8'd1;
    end
  end
`endif

endmodule

// File: rtl/debounce_multi_us.sv
// N-channel input debouncer with one aggregated change strobe and mask per update.
// Latency: 2 + DEBOUNCE_CYCLES clocks per channel; no backpressure (free-running).
// DEBOUNCE_GLITCH_CNT_EN exposes per-channel 8-bit glitch counters on glitch_count.
module debounce_multi_us
  import debounce_multi_us_pkg::*;
#(
  parameter int                  CHANNELS         = 3,
  parameter int                  CLK_FREQ_HZ      = 50_000_000,
  parameter int                  DEBOUNCE_TIME_US = 50,
  parameter logic [CHANNELS-1:0] RESET_VALUE      = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] signal_in,
  output logic [CHANNELS-1:0] signal_out,
  output logic                changed,
  output logic [CHANNELS-1:0] change_mask
`ifdef DEBOUNCE_GLITCH_CNT_EN
  ,
  output logic [CHANNELS*8-1:0] glitch_count
`endif
);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    debounce_channel #(
      .CLK_FREQ_HZ     (CLK_FREQ_HZ),
      .DEBOUNCE_TIME_US(DEBOUNCE_TIME_US),
      .RESET_BIT       (RESET_VALUE[g])
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .signal_in (signal_in[g]),
      .signal_out(signal_out[g]),
      .update    (change_mask[g])
`ifdef DEBOUNCE_GLITCH_CNT_EN
      ,
      .glitch_count(glitch_count[g*8 +: 8])
`endif
    );
  end

  // Mask bits are flops, so the strobe lines up with the new signal_out value.
  assign changed = |change_mask;

endmodule
